obstacle_scan_generator: RTL

Pixel-side producer for the obstacle display path. Converts the VGA scan position and the camera's world offset into tile-local ROM coordinates, absolute tile position and an `obstacle_on` qualifier, feeding the obstacle display controller in a fixed two-cycle pipeline. It fetches one obstacle-map row per scanline from map memory over a req/ack handshake during horizontal blanking, double-buffered so the active line is never disturbed.

---
 rtl/obstacle_scan_generator.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/obstacle_scan_generator.sv
// Obstacle scan producer: maps scan position + camera offset to tile-local ROM coordinates and
// occupancy, fetching one map row per line during hblank into a double-buffered line store.
module obstacle_scan_generator #(
  parameter int unsigned SCREEN_WIDTH    = 10,
  parameter int unsigned PHY_WIDTH       = 14,
  parameter int unsigned OBSTACLE_WIDTH  = 10,
  parameter int unsigned OBSTACLE_HEIGHT = 20,
  parameter int unsigned MAP_COLS        = 64,
  parameter int unsigned H_ACTIVE        = 640
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [SCREEN_WIDTH-1:0] pixel_x,
  input  logic [SCREEN_WIDTH-1:0] pixel_y,
  input  logic                    pixel_valid,
  input  logic                    line_start,
  input  logic [SCREEN_WIDTH-1:0] next_line_y,
  input  logic [PHY_WIDTH-1:0]    camera_y,
  output logic                    map_req,
  output logic [PHY_WIDTH-1:0]    map_row_addr,
  input  logic                    map_ack,
  input  logic [MAP_COLS-1:0]     map_row_data,
  output logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  output logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  output logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  output logic                    obstacle_on,
  output logic                    out_valid,
  output logic                    fetch_underrun
);

  localparam logic [SCREEN_WIDTH-1:0] XWrap    = SCREEN_WIDTH'(OBSTACLE_WIDTH - 1);
  localparam logic [SCREEN_WIDTH-1:0] MapColsW = SCREEN_WIDTH'(MAP_COLS);
  localparam logic [SCREEN_WIDTH-1:0] MaxCols  =
      SCREEN_WIDTH'((H_ACTIVE + OBSTACLE_WIDTH - 1) / OBSTACLE_WIDTH);
  localparam logic [PHY_WIDTH-1:0]    TileW    = PHY_WIDTH'(OBSTACLE_WIDTH);
  localparam logic [PHY_WIDTH-1:0]    TileH    = PHY_WIDTH'(OBSTACLE_HEIGHT);
  localparam int unsigned             ColIdxW  = $clog2(MAP_COLS);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  state_e state_q, state_d;

  logic [PHY_WIDTH-1:0]    wy_fresh, wy_src, wy_rem;
  logic [PHY_WIDTH-1:0]    addr_q, addr_d, pend_wy_q, pend_wy_d;
  logic [PHY_WIDTH-1:0]    req_base_q, req_base_d, shadow_base_q, shadow_base_d;
  logic [PHY_WIDTH-1:0]    line_base_q, line_base_d;
  logic [SCREEN_WIDTH-1:0] req_yin_q, req_yin_d, shadow_yin_q, shadow_yin_d;
  logic [SCREEN_WIDTH-1:0] line_yin_q, line_yin_d;
  logic                    pending_q, pending_d, shadow_ok_q, shadow_ok_d;
  logic                    underrun_q, underrun_d;
  logic [MAP_COLS-1:0]     shadow_q, shadow_d, active_q, active_d;
  logic                    launch, ack_fire, swap;

  logic [SCREEN_WIDTH-1:0] xin_q, xin_d, col_q, col_d, cur_xin, cur_col;
  logic [PHY_WIDTH-1:0]    absx_q, absx_d, cur_absx;
  logic                    s1_valid_q;
  logic [SCREEN_WIDTH-1:0] s1_xin_q, s1_col_q;
  logic [PHY_WIDTH-1:0]    s1_absx_q;
  logic                    tile_hit;

  logic [SCREEN_WIDTH-1:0] x_rom_q, x_rom_d, y_rom_q, y_rom_d;
  logic [PHY_WIDTH-1:0]    abs_x_q, abs_x_d, abs_y_q, abs_y_d;
  logic                    on_q, on_d, out_valid_q;

  logic unused_pixel_y;
  assign unused_pixel_y = ^pixel_y;

  // World y is computed from inputs sampled at line_start, or replayed from the pending record.
  assign wy_fresh = camera_y + PHY_WIDTH'(next_line_y);
  assign wy_src   = line_start ? wy_fresh : pend_wy_q;
  assign wy_rem   = wy_src % TileH;

  assign launch   = (state_q == StIdle) && (line_start || pending_q);
  assign ack_fire = (state_q == StReq) && map_ack;
  assign swap     = pixel_valid && (pixel_x == '0);

  // Fetch FSM: state register, next-state logic, outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (line_start || pending_q) state_d = StReq;
      StReq:   if (map_ack) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    map_req = (state_q == StReq);
  end

  always_comb begin
    addr_d        = addr_q;
    req_yin_d     = req_yin_q;
    req_base_d    = req_base_q;
    pending_d     = pending_q;
    pend_wy_d     = pend_wy_q;
    shadow_d      = shadow_q;
    shadow_yin_d  = shadow_yin_q;
    shadow_base_d = shadow_base_q;
    shadow_ok_d   = shadow_ok_q;
    active_d      = active_q;
    line_yin_d    = line_yin_q;
    line_base_d   = line_base_q;
    underrun_d    = 1'b0;
    if (launch) begin
      addr_d     = wy_src / TileH;
      req_yin_d  = SCREEN_WIDTH'(wy_rem);
      req_base_d = wy_src - wy_rem;
      pending_d  = 1'b0;
    end else if ((state_q == StReq) && line_start) begin
      pending_d = 1'b1;
      pend_wy_d = wy_fresh;
    end
    if (ack_fire) begin
      shadow_d      = map_row_data;
      shadow_yin_d  = req_yin_q;
      shadow_base_d = req_base_q;
    end
    if (swap) begin
      active_d    = shadow_ok_q ? shadow_q : '0;
      line_yin_d  = shadow_yin_q;
      line_base_d = shadow_base_q;
      underrun_d  = !shadow_ok_q;
      shadow_ok_d = 1'b0;
    end
    // A superseded fetch still lands in the shadow but is never marked displayable.
    if (ack_fire && !pending_q && !line_start) shadow_ok_d = 1'b1;
  end

  // Column tracking by counting, so no divider is needed on x.
  assign cur_xin  = (pixel_x == '0) ? '0 : xin_q;
  assign cur_col  = (pixel_x == '0) ? '0 : col_q;
  assign cur_absx = (pixel_x == '0) ? '0 : absx_q;

  always_comb begin
    xin_d  = cur_xin;
    col_d  = cur_col;
    absx_d = cur_absx;
    if (pixel_valid) begin
      if (cur_xin == XWrap) begin
        xin_d = '0;
        if (cur_col != MaxCols) begin
          col_d  = cur_col + 1'b1;
          absx_d = cur_absx + TileW;
        end
      end else begin
        xin_d = cur_xin + 1'b1;
      end
    end
  end

  assign tile_hit = (s1_col_q < MapColsW) && active_q[s1_col_q[ColIdxW-1:0]];

  always_comb begin
    x_rom_d = x_rom_q;
    y_rom_d = y_rom_q;
    abs_x_d = abs_x_q;
    abs_y_d = abs_y_q;
    on_d    = s1_valid_q && tile_hit;
    if (s1_valid_q) begin
      x_rom_d = s1_xin_q;
      y_rom_d = line_yin_q;
      abs_x_d = s1_absx_q;
      abs_y_d = line_base_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      addr_q        <= '0;
      req_yin_q     <= '0;
      req_base_q    <= '0;
      pending_q     <= 1'b0;
      pend_wy_q     <= '0;
      shadow_q      <= '0;
      shadow_yin_q  <= '0;
      shadow_base_q <= '0;
      shadow_ok_q   <= 1'b0;
      active_q      <= '0;
      line_yin_q    <= '0;
      line_base_q   <= '0;
      underrun_q    <= 1'b0;
      xin_q         <= '0;
      col_q         <= '0;
      absx_q        <= '0;
      s1_valid_q    <= 1'b0;
      s1_xin_q      <= '0;
      s1_col_q      <= '0;
      s1_absx_q     <= '0;
      x_rom_q       <= '0;
      y_rom_q       <= '0;
      abs_x_q       <= '0;
      abs_y_q       <= '0;
      on_q          <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      req_yin_q     <= req_yin_d;
      req_base_q    <= req_base_d;
      pending_q     <= pending_d;
      pend_wy_q     <= pend_wy_d;
      shadow_q      <= shadow_d;
      shadow_yin_q  <= shadow_yin_d;
      shadow_base_q <= shadow_base_d;
      shadow_ok_q   <= shadow_ok_d;
      active_q      <= active_d;
      line_yin_q    <= line_yin_d;
      line_base_q   <= line_base_d;
      underrun_q    <= underrun_d;
      xin_q         <= xin_d;
      col_q         <= col_d;
      absx_q        <= absx_d;
      s1_valid_q    <= pixel_valid;
      s1_xin_q      <= cur_xin;
      s1_col_q      <= cur_col;
      s1_absx_q     <= cur_absx;
      x_rom_q       <= x_rom_d;
      y_rom_q       <= y_rom_d;
      abs_x_q       <= abs_x_d;
      abs_y_q       <= abs_y_d;
      on_q          <= on_d;
      out_valid_q   <= s1_valid_q;
    end
  end

  assign map_row_addr       = addr_q;
  assign obstacle_x_rom     = x_rom_q;
  assign obstacle_y_rom     = y_rom_q;
  assign obstacle_abs_pos_x = abs_x_q;
  assign obstacle_abs_pos_y = abs_y_q;
  assign obstacle_on        = on_q;
  assign out_valid          = out_valid_q;
  assign fetch_underrun     = underrun_q;

endmodule
